// File: rtl/osr_autopull.sv
// rtl/osr_autopull.sv - output shift register with explicit PULL and threshold autopull from a TX FIFO
// OUT, PULL and idle refill share one pop path, so at most one FIFO word moves per cycle.
module osr_autopull (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_pull,
  input  logic        out_en,
  input  logic [4:0]  out_bits,
  input  logic        pull_en,
  input  logic        pull_block,
  input  logic [31:0] x_in,
  input  logic        shift_right,
  input  logic        autopull_en,
  input  logic [4:0]  pull_thresh,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        stall,
  output logic [5:0]  shift_count
);

  logic [31:0] osr_q, osr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        pop, stall_c, need;
  logic [5:0]  n, thr;
  logic [6:0]  sum;

  assign n    = (out_bits == 5'd0) ? 6'd32 : {1'b0, out_bits};
  assign thr  = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
  assign need = autopull_en && (cnt_q >= thr);
  assign sum  = {1'b0, cnt_q} + {1'b0, n};

  always_comb begin
    osr_d       = osr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    pop         = 1'b0;
    stall_c     = 1'b0;
    if (!reset) begin
      if (pull_en) begin
        // With autopull on, an explicit PULL below threshold is a no-op.
        if (!(autopull_en && cnt_q < thr)) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else if (pull_block) begin
            stall_c = 1'b1;
          end else begin
            osr_d = x_in;
            cnt_d = 6'd0;
          end
        end
      end else if (out_en) begin
        if (need) begin
          stall_c = 1'b1;
          pop     = !fifo_empty;
        end else begin
          if (shift_right) begin
            out_data_d = osr_q & ~(32'hFFFF_FFFF << n);
            osr_d      = osr_q >> n;
          end else begin
            out_data_d = osr_q >> (6'd32 - n);
            osr_d      = osr_q << n;
          end
          out_valid_d = 1'b1;
          cnt_d       = (sum > 7'd32) ? 6'd32 : sum[5:0];
        end
      end else if (need && !fifo_empty) begin
        pop = 1'b1;
      end
      if (pop) begin
        osr_d = fifo_dout;
        cnt_d = 6'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      osr_q       <= 32'd0;
      cnt_q       <= 6'd32;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      osr_q       <= osr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_pull   = pop;
  assign stall       = stall_c;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign shift_count = cnt_q;

endmodule

// File: tb/tb_osr_autopull.sv
// tb/tb_osr_autopull.sv - scenario tasks with a FIFO model and an expected-OUT scoreboard
// Combinational outputs are sampled on the falling edge, registered ones 1ns after the rising edge.
module tb_osr_autopull;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fifo_dout = 32'd0;
  logic        fifo_empty = 1'b1;
  logic        fifo_pull;
  logic        out_en = 1'b0;
  logic [4:0]  out_bits = 5'd0;
  logic        pull_en = 1'b0;
  logic        pull_block = 1'b0;
  logic [31:0] x_in = 32'd0;
  logic        shift_right = 1'b1;
  logic        autopull_en = 1'b0;
  logic [4:0]  pull_thresh = 5'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        stall;
  logic [5:0]  shift_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          bad_pops = 0;
  logic        s_pull, s_stall;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  osr_autopull dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_pull(fifo_pull), .out_en(out_en), .out_bits(out_bits), .pull_en(pull_en),
    .pull_block(pull_block), .x_in(x_in), .shift_right(shift_right),
    .autopull_en(autopull_en), .pull_thresh(pull_thresh), .out_data(out_data),
    .out_valid(out_valid), .stall(stall), .shift_count(shift_count)
  );

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 32'd0 : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic cycle();
    @(negedge clk);
    s_pull  = fifo_pull;
    s_stall = stall;
    @(posedge clk);
    if (s_pull) begin
      if (fifo_q.size() == 0) bad_pops++;
      else void'(fifo_q.pop_front());
    end
    #1;
    refresh();
  endtask

  task automatic idle();
    out_en = 1'b0; pull_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pull_en = 1'b1; out_en = 1'b1; push(32'h1234_5678);
    cycle();
    tests_run++; if (s_pull !== 1'b0) begin tests_failed++; $display("FAIL rst_pull: got %b want 0", s_pull); end
    tests_run++; if (s_stall !== 1'b0) begin tests_failed++; $display("FAIL rst_stall: got %b want 0", s_stall); end
    cycle();
    tests_run++; if (shift_count !== 6'd32) begin tests_failed++; $display("FAIL rst_cnt: got %0d want 32", shift_count); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    tests_run++; if (out_data !== 32'd0) begin tests_failed++; $display("FAIL rst_data: got %h want 0", out_data); end
    tests_run++; if (fifo_q.size() != 1) begin tests_failed++; $display("FAIL rst_nopop: fifo size %0d want 1", fifo_q.size()); end
    fifo_q.delete(); refresh(); idle();
    reset = 1'b0;
  endtask

  task automatic test_blocking_pull();
    autopull_en = 1'b0; pull_en = 1'b1; pull_block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++; if (s_stall !== 1'b1 || s_pull !== 1'b0) begin tests_failed++; $display("FAIL bp_stall%0d: got stall %b pull %b want 1 0", k, s_stall, s_pull); end
      tests_run++; if (shift_count !== 6'd32) begin tests_failed++; $display("FAIL bp_hold%0d: got %0d want 32", k, shift_count); end
    end
    push(32'hA5A5_0F0F);
    cycle();
    tests_run++; if (s_stall !== 1'b0 || s_pull !== 1'b1) begin tests_failed++; $display("FAIL bp_pop: got stall %b pull %b want 0 1", s_stall, s_pull); end
    tests_run++; if (shift_count !== 6'd0) begin tests_failed++; $display("FAIL bp_cnt: got %0d want 0", shift_count); end
    idle(); out_en = 1'b1; out_bits = 5'd0; shift_right = 1'b1; exp_q.push_back(32'hA5A5_0F0F);
    cycle(); idle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL bp_out: got valid %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL bp_out: got %h want %h", out_data, e); end end
  endtask

  task automatic load_x(input logic [31:0] v);
    autopull_en = 1'b0; pull_block = 1'b0; pull_en = 1'b1; x_in = v;
    cycle(); idle();
  endtask

  task automatic test_right_out();
    load_x(32'h4433_2211);
    out_en = 1'b1; out_bits = 5'd8; shift_right = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h11 * (k + 1));
      cycle();
      tests_run++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL ro_valid%0d: got %b want 1", k, out_valid); end
      else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL ro_data%0d: got %h want %h", k, out_data, e); end end
      tests_run++; if (shift_count !== 6'(8 * (k + 1))) begin tests_failed++; $display("FAIL ro_cnt%0d: got %0d want %0d", k, shift_count, 8 * (k + 1)); end
    end
    idle(); cycle();
    tests_run++; if (out_valid !== 1'b0 || out_data !== 32'h44) begin tests_failed++; $display("FAIL ro_hold: got valid %b data %h want 0 44", out_valid, out_data); end
  endtask

  task automatic test_left_out();
    load_x(32'hF000_0001);
    out_en = 1'b1; out_bits = 5'd4; shift_right = 1'b0; exp_q.push_back(32'hF);
    cycle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL lo_valid: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL lo_data: got %h want %h", out_data, e); end end
    tests_run++; if (shift_count !== 6'd4) begin tests_failed++; $display("FAIL lo_cnt: got %0d want 4", shift_count); end
    out_bits = 5'd28; exp_q.push_back(32'h000_0001);
    cycle(); idle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL lo_rest_valid: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL lo_rest: got %h want %h", out_data, e); end end
    tests_run++; if (shift_count !== 6'd32) begin tests_failed++; $display("FAIL lo_cnt2: got %0d want 32", shift_count); end
  endtask

  task automatic test_autopull();
    logic [3:0] exp_stall = 4'b0101;
    autopull_en = 1'b1; pull_thresh = 5'd0; shift_right = 1'b1; out_bits = 5'd0;
    push(32'h1); push(32'h2);
    exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    out_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++; if (s_stall !== exp_stall[k] || s_pull !== exp_stall[k]) begin tests_failed++; $display("FAIL ap_stall%0d: got stall %b pull %b want %b", k, s_stall, s_pull, exp_stall[k]); end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL ap_extra: got %h want none", out_data); end
        else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL ap_data%0d: got %h want %h", k, out_data, e); end end
      end
    end
    cycle(); idle();
    tests_run++; if (s_stall !== 1'b1 || s_pull !== 1'b0) begin tests_failed++; $display("FAIL ap_empty: got stall %b pull %b want 1 0", s_stall, s_pull); end
    tests_run++; if (exp_q.size() != 0 || bad_pops != 0) begin tests_failed++; $display("FAIL ap_sb: got %0d left %0d bad pops want 0 0", exp_q.size(), bad_pops); end
  endtask

  task automatic test_nonblocking_pull();
    autopull_en = 1'b0; pull_block = 1'b0; pull_en = 1'b1; x_in = 32'hDEAD_BEEF;
    cycle(); idle();
    tests_run++; if (s_stall !== 1'b0 || s_pull !== 1'b0) begin tests_failed++; $display("FAIL nb_comb: got stall %b pull %b want 0 0", s_stall, s_pull); end
    tests_run++; if (shift_count !== 6'd0) begin tests_failed++; $display("FAIL nb_cnt: got %0d want 0", shift_count); end
    out_en = 1'b1; out_bits = 5'd0; shift_right = 1'b1; exp_q.push_back(32'hDEAD_BEEF);
    cycle(); idle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL nb_valid: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL nb_data: got %h want %h", out_data, e); end end
  endtask

  task automatic test_priority_and_zeros();
    pull_en = 1'b1; out_en = 1'b1; out_bits = 5'd8; x_in = 32'h0000_00AB;
    cycle();
    tests_run++; if (out_valid !== 1'b0 || shift_count !== 6'd0) begin tests_failed++; $display("FAIL pr_ign: got valid %b cnt %0d want 0 0", out_valid, shift_count); end
    pull_en = 1'b0; exp_q.push_back(32'hAB);
    cycle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL pr_valid: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL pr_data: got %h want %h", out_data, e); end end
    out_bits = 5'd0; cycle(); cycle();
    tests_run++; if (s_stall !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd0 || shift_count !== 6'd32) begin tests_failed++; $display("FAIL zero_out: got stall %b valid %b data %h cnt %0d want 0 1 0 32", s_stall, out_valid, out_data, shift_count); end
    idle();
  endtask

  task automatic test_saturation();
    load_x(32'hC000_0005);
    out_en = 1'b1; shift_right = 1'b1; out_bits = 5'd30; exp_q.push_back(32'h5);
    cycle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL sat_v1: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e || shift_count !== 6'd30) begin tests_failed++; $display("FAIL sat_30: got %h cnt %0d want %h 30", out_data, shift_count, e); end end
    out_bits = 5'd8; exp_q.push_back(32'h3);
    cycle(); idle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL sat_v2: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e || shift_count !== 6'd32) begin tests_failed++; $display("FAIL sat_32: got %h cnt %0d want %h 32", out_data, shift_count, e); end end
  endtask

  task automatic test_idle_refill();
    autopull_en = 1'b1; pull_thresh = 5'd8; push(32'h77);
    cycle();
    tests_run++; if (s_pull !== 1'b1 || s_stall !== 1'b0) begin tests_failed++; $display("FAIL ir_pop: got pull %b stall %b want 1 0", s_pull, s_stall); end
    tests_run++; if (out_valid !== 1'b0 || shift_count !== 6'd0) begin tests_failed++; $display("FAIL ir_state: got valid %b cnt %0d want 0 0", out_valid, shift_count); end
    out_en = 1'b1; out_bits = 5'd8; shift_right = 1'b1; exp_q.push_back(32'h77);
    cycle(); idle();
    tests_run++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin tests_failed++; $display("FAIL ir_valid: got %b want 1", out_valid); end
    else begin e = exp_q.pop_front(); if (out_data !== e) begin tests_failed++; $display("FAIL ir_data: got %h want %h", out_data, e); end end
  endtask

  task automatic test_reset_mid_stall();
    autopull_en = 1'b0; pull_block = 1'b1; pull_en = 1'b1;
    cycle();
    tests_run++; if (s_stall !== 1'b1) begin tests_failed++; $display("FAIL rs_pre: got stall %b want 1", s_stall); end
    reset = 1'b1; push(32'h99);
    cycle();
    tests_run++; if (s_pull !== 1'b0 || s_stall !== 1'b0) begin tests_failed++; $display("FAIL rs_comb: got pull %b stall %b want 0 0", s_pull, s_stall); end
    tests_run++; if (shift_count !== 6'd32 || out_valid !== 1'b0 || fifo_q.size() != 1) begin tests_failed++; $display("FAIL rs_state: got cnt %0d valid %b fifo %0d want 32 0 1", shift_count, out_valid, fifo_q.size()); end
    idle(); reset = 1'b0; fifo_q.delete(); refresh();
  endtask

  initial begin
    test_reset();
    test_blocking_pull();
    test_right_out();
    test_left_out();
    test_autopull();
    test_nonblocking_pull();
    test_priority_and_zeros();
    test_saturation();
    test_idle_refill();
    test_reset_mid_stall();
    tests_run++; if (bad_pops != 0) begin tests_failed++; $display("FAIL empty_pop: got %0d want 0", bad_pops); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
